ml_tile_sequencer: RTL and testbench

- Parametrised control sequencer for the PE array. It loops one DNN layer over N tiles: weight load, ifmap SRAM-to-buffer, buffer-to-PE row load, compute, PE-to-buffer ofmap unload, buffer-to-SRAM drain.
- Replaces the fixed single-pass controller. Adds configurable row counts, tile looping, an optional weight reload, req/ack handshakes, a compute timeout, abort and error reporting.
- Sits between the host/DMA command layer and the PE array, ifmap FIFO and ofmap FIFO.

---
 rtl/ml_ctrl_pkg.sv | 23 ++
 rtl/ml_row_stepper.sv | 37 +++
 rtl/ml_tile_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_ml_tile_sequencer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ml_ctrl_pkg.sv
// Shared types and constants for the PE-array tile sequencer.
// Holds the FSM state encoding, error codes and the default row-counter width.
package ml_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        LD_WT        = 3'd1,
        LD_IF_BUF    = 3'd2,
        LD_IF_PE     = 3'd3,
        EXEC         = 3'd4,
        UNLD_OF_PE   = 3'd5,
        UNLD_OF_SRAM = 3'd6,
        FIN          = 3'd7
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_CFG     = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    localparam int Y_DIM_DEF = 15;
    localparam int ROW_W     = $clog2(Y_DIM_DEF + 1);

endpackage

// File: rtl/ml_row_stepper.sv
// Walks a one-hot row select across 0..limit-1, one row per unstalled cycle.
// Ports: clk, rst_n; enable, stall, clr, limit in; sel, strobe, last out.
module ml_row_stepper #(
    parameter int Y_DIM = 15
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic                         stall,
    input  logic                         clr,
    input  logic [$clog2(Y_DIM+1)-1:0]   limit,
    output logic [Y_DIM-1:0]             sel,
    output logic                         strobe,
    output logic                         last
);

    localparam int RW = $clog2(Y_DIM + 1);

    logic [RW-1:0] row;

    always_comb begin
        strobe = enable && !stall;
        last   = strobe && (row == limit - RW'(1));
        sel    = strobe ? (Y_DIM'(1) << row) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row <= '0;
        end else if (clr || last) begin
            row <= '0;
        end else if (strobe) begin
            row <= row + RW'(1);
        end
    end

endmodule

// File: rtl/ml_tile_sequencer.sv
// Tile-looping controller: weights, ifmap fill, row load, compute, unload, drain.
// Ports: clk/rst_n, start/abort, cfg_*; req/ack engine handshakes; FIFO strobes,
// row selects, pe_start/pe_done to the array; busy/done/err/state_o/tile_idx.
module ml_tile_sequencer
    import ml_ctrl_pkg::*;
#(
    parameter int                   Y_DIM     = 15,
    parameter int                   TILE_W    = 8,
    parameter int                   TIMEOUT_W = 16,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT   = 16'hFFFF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       abort,
    input  logic [TILE_W-1:0]          cfg_num_tiles,
    input  logic [$clog2(Y_DIM+1)-1:0] cfg_if_rows,
    input  logic [$clog2(Y_DIM+1)-1:0] cfg_of_rows,
    input  logic                       cfg_wt_reload,
    output logic                       wt_ld_req,
    input  logic                       wt_ld_ack,
    output logic                       if_buf_req,
    input  logic                       if_buf_done,
    input  logic                       if_fifo_empty,
    output logic                       if_fifo_rd_en,
    output logic [Y_DIM-1:0]           pe_if_row_sel,
    output logic                       pe_start,
    input  logic                       pe_done,
    input  logic                       of_fifo_full,
    output logic                       of_fifo_wr_en,
    output logic [Y_DIM-1:0]           pe_of_row_sel,
    output logic                       of_drain_req,
    input  logic                       of_drain_done,
    output logic                       busy,
    output logic                       done,
    output logic [1:0]                 err,
    output logic [2:0]                 state_o,
    output logic [TILE_W-1:0]          tile_idx
);

    localparam int            RW   = $clog2(Y_DIM + 1);
    localparam logic [RW-1:0] YMAX = RW'(Y_DIM);

    state_t               state, state_n;
    logic [TILE_W-1:0]    n_tiles, tile_nxt;
    logic [RW-1:0]        if_rows, of_rows;
    logic                 reload;
    logic [TIMEOUT_W-1:0] wdog;
    logic                 armed;
    logic                 ab, cfg_bad, tile_end, timeout;
    logic                 if_last, of_last;

    ml_row_stepper #(.Y_DIM(Y_DIM)) u_if_step (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable ((state == LD_IF_PE) && !abort),
        .stall  (if_fifo_empty),
        .clr    (ab),
        .limit  (if_rows),
        .sel    (pe_if_row_sel),
        .strobe (if_fifo_rd_en),
        .last   (if_last)
    );

    ml_row_stepper #(.Y_DIM(Y_DIM)) u_of_step (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable ((state == UNLD_OF_PE) && !abort),
        .stall  (of_fifo_full),
        .clr    (ab),
        .limit  (of_rows),
        .sel    (pe_of_row_sel),
        .strobe (of_fifo_wr_en),
        .last   (of_last)
    );

    always_comb begin
        ab       = abort && (state != IDLE);
        cfg_bad  = (cfg_num_tiles == '0)
                || (cfg_if_rows == '0) || (cfg_if_rows > YMAX)
                || (cfg_of_rows == '0) || (cfg_of_rows > YMAX);
        tile_nxt = tile_idx + TILE_W'(1);
        tile_end = (tile_nxt == n_tiles);
        // armed is low only on the first EXEC cycle, so the watchdog
        // starts counting on the cycle after the pe_start pulse
        timeout  = (state == EXEC) && armed && (wdog == TIMEOUT);
    end

    always_comb begin
        state_n      = state;
        wt_ld_req    = 1'b0;
        if_buf_req   = 1'b0;
        of_drain_req = 1'b0;
        pe_start     = 1'b0;
        done         = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_n = cfg_bad ? FIN : LD_WT;
            end
            LD_WT: begin
                wt_ld_req = 1'b1;
                if (wt_ld_ack) state_n = LD_IF_BUF;
            end
            LD_IF_BUF: begin
                if_buf_req = 1'b1;
                if (if_buf_done) state_n = LD_IF_PE;
            end
            LD_IF_PE: begin
                if (if_last) state_n = EXEC;
            end
            EXEC: begin
                pe_start = !armed;
                if (timeout) state_n = FIN;
                else if (pe_done) state_n = UNLD_OF_PE;
            end
            UNLD_OF_PE: begin
                if (of_last) state_n = UNLD_OF_SRAM;
            end
            UNLD_OF_SRAM: begin
                of_drain_req = 1'b1;
                if (of_drain_done) begin
                    if (tile_end) state_n = FIN;
                    else if (reload) state_n = LD_WT;
                    else state_n = LD_IF_BUF;
                end
            end
            FIN: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (ab) begin
            state_n      = IDLE;
            wt_ld_req    = 1'b0;
            if_buf_req   = 1'b0;
            of_drain_req = 1'b0;
            pe_start     = 1'b0;
            done         = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            n_tiles  <= '0;
            if_rows  <= '0;
            of_rows  <= '0;
            reload   <= 1'b0;
            tile_idx <= '0;
            wdog     <= '0;
            armed    <= 1'b0;
            err      <= ERR_NONE;
        end else begin
            state <= state_n;
            if (state == IDLE && start) begin
                n_tiles  <= cfg_num_tiles;
                if_rows  <= cfg_if_rows;
                of_rows  <= cfg_of_rows;
                reload   <= cfg_wt_reload;
                tile_idx <= '0;
                err      <= cfg_bad ? ERR_CFG : ERR_NONE;
            end
            if (timeout && !ab) err <= ERR_TIMEOUT;
            if (state == EXEC && state_n == EXEC) begin
                armed <= 1'b1;
                if (armed) wdog <= wdog + TIMEOUT_W'(1);
            end else begin
                armed <= 1'b0;
                wdog  <= '0;
            end
            if (ab) begin
                tile_idx <= '0;
            end else if (state == UNLD_OF_SRAM && of_drain_done && !tile_end) begin
                tile_idx <= tile_nxt;
            end
        end
    end

    assign busy    = (state != IDLE);
    assign state_o = state;

endmodule

// File: tb/tb_ml_tile_sequencer.sv
// Self-checking bench for ml_tile_sequencer: job table with a scoreboard,
// per-cycle row-select monitor, and timeout / bad-config / abort sequences.
`timescale 1ns/1ps
module tb_ml_tile_sequencer;
    import ml_ctrl_pkg::*;

    localparam int Y       = 15;
    localparam int RW      = ROW_W;
    localparam int TW      = 8;
    localparam int ACK_LAT = 3;
    localparam int BUDGET  = 3000;
    localparam int SW      = 2 * Y + 7;

    typedef struct {
        int tiles;
        int ifr;
        int ofr;
        bit reload;
        bit stall;
        int e_err;
        int e_wt;
        int e_st;
        int e_rd;
        int e_wr;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n, start, abort;
    logic [TW-1:0] cfg_num_tiles;
    logic [RW-1:0] cfg_if_rows, cfg_of_rows;
    logic          cfg_wt_reload;
    logic          wt_ld_req, wt_ld_ack, if_buf_req, if_buf_done;
    logic          if_fifo_empty, if_fifo_rd_en;
    logic [Y-1:0]  pe_if_row_sel, pe_of_row_sel;
    logic          pe_start, pe_done, of_fifo_full, of_fifo_wr_en;
    logic          of_drain_req, of_drain_done, busy, done;
    logic [1:0]    err;
    logic [2:0]    state_o;
    logic [TW-1:0] tile_idx;

    logic [SW-1:0]    strb;
    logic [SW+13:0]   outv;
    assign strb = {wt_ld_req, if_buf_req, if_fifo_rd_en, pe_if_row_sel,
                   pe_start, of_fifo_wr_en, pe_of_row_sel, of_drain_req, done};
    assign outv = {strb, busy, err, state_o, tile_idx};

    int   checks = 0, errors = 0, cyc = 0;
    int   rd_cnt, wr_cnt, wt_tx, st_cnt, done_cnt;
    int   exp_if_row, exp_of_row, cur_if, cur_of, exp_tile;
    int   last_rd_cyc, pe_start_cyc, done_cyc, start_cyc;
    bit   req_seen, stall_mode = 1'b0, done_en = 1'b1;
    vec_t sb[$];
    vec_t tab[8];

    ml_tile_sequencer #(
        .Y_DIM(Y), .TILE_W(TW), .TIMEOUT_W(16), .TIMEOUT(16'd20)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .cfg_num_tiles(cfg_num_tiles), .cfg_if_rows(cfg_if_rows),
        .cfg_of_rows(cfg_of_rows), .cfg_wt_reload(cfg_wt_reload),
        .wt_ld_req(wt_ld_req), .wt_ld_ack(wt_ld_ack),
        .if_buf_req(if_buf_req), .if_buf_done(if_buf_done),
        .if_fifo_empty(if_fifo_empty), .if_fifo_rd_en(if_fifo_rd_en),
        .pe_if_row_sel(pe_if_row_sel), .pe_start(pe_start),
        .pe_done(pe_done), .of_fifo_full(of_fifo_full),
        .of_fifo_wr_en(of_fifo_wr_en), .pe_of_row_sel(pe_of_row_sel),
        .of_drain_req(of_drain_req), .of_drain_done(of_drain_done),
        .busy(busy), .done(done), .err(err), .state_o(state_o),
        .tile_idx(tile_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [Y-1:0] oh(input int r);
        logic [Y-1:0] v;
        v = '0;
        if (r >= 0 && r < Y) v[r] = 1'b1;
        return v;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Engine responders: each ack after ACK_LAT cycles of req,
    // pe_done two cycles after pe_start unless disabled.
    initial begin
        int cw = 0, cb = 0, cd = 0, pd = 0;
        wt_ld_ack = 0; if_buf_done = 0; of_drain_done = 0; pe_done = 0;
        forever begin
            @(posedge clk); #2;
            wt_ld_ack = 0; if_buf_done = 0; of_drain_done = 0; pe_done = 0;
            cw = wt_ld_req ? cw + 1 : 0;
            cb = if_buf_req ? cb + 1 : 0;
            cd = of_drain_req ? cd + 1 : 0;
            if (cw == ACK_LAT) begin wt_ld_ack = 1; cw = 0; end
            if (cb == ACK_LAT) begin if_buf_done = 1; cb = 0; end
            if (cd == ACK_LAT) begin of_drain_done = 1; cd = 0; end
            if (pd > 0) begin
                pd--;
                if (pd == 0) pe_done = done_en;
            end
            if (pe_start) pd = 2;
        end
    end

    initial begin
        if_fifo_empty = 0; of_fifo_full = 0;
        forever begin
            @(posedge clk); #1;
            if_fifo_empty = stall_mode ? ~if_fifo_empty : 1'b0;
            of_fifo_full  = stall_mode ? ~of_fifo_full : 1'b0;
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (if_fifo_rd_en) begin
                rd_cnt++;
                last_rd_cyc = cyc;
                check("rd_while_empty", 64'(if_fifo_empty), 0);
                check("if_row_sel", 64'(pe_if_row_sel), 64'(oh(exp_if_row)));
                exp_if_row = (exp_if_row + 1 >= cur_if) ? 0 : exp_if_row + 1;
            end else if (pe_if_row_sel != '0) begin
                check("if_sel_idle", 64'(pe_if_row_sel), 0);
            end
            if (of_fifo_wr_en) begin
                wr_cnt++;
                check("wr_while_full", 64'(of_fifo_full), 0);
                check("of_row_sel", 64'(pe_of_row_sel), 64'(oh(exp_of_row)));
                exp_of_row = (exp_of_row + 1 >= cur_of) ? 0 : exp_of_row + 1;
            end else if (pe_of_row_sel != '0) begin
                check("of_sel_idle", 64'(pe_of_row_sel), 0);
            end
            if (wt_ld_req && wt_ld_ack) wt_tx++;
            if (wt_ld_req || if_buf_req || of_drain_req) req_seen = 1;
            if (pe_start) begin
                st_cnt++;
                pe_start_cyc = cyc;
                check("exec_after_last_pop", 64'(cyc), 64'(last_rd_cyc + 1));
                check("tile_idx", 64'(tile_idx), 64'(exp_tile));
                exp_tile++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic kick(input vec_t v, input bit pe_ok);
        @(posedge clk); #1;
        cfg_num_tiles = TW'(v.tiles);
        cfg_if_rows   = RW'(v.ifr);
        cfg_of_rows   = RW'(v.ofr);
        cfg_wt_reload = v.reload;
        stall_mode    = v.stall;
        done_en       = pe_ok;
        rd_cnt = 0; wr_cnt = 0; wt_tx = 0; st_cnt = 0; done_cnt = 0;
        exp_if_row = 0; exp_of_row = 0; exp_tile = 0; req_seen = 0;
        cur_if = v.ifr; cur_of = v.ofr;
        start = 1'b1;
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_job(input vec_t v, input bit pe_ok);
        vec_t e;
        int   n;
        sb.push_back(v);
        kick(v, pe_ok);
        n = 0;
        while (n < BUDGET && done_cnt == 0) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        e = sb.pop_front();
        check("done_within_budget", 64'(n < BUDGET), 1);
        check("done_pulses", 64'(done_cnt), 1);
        check("idle_after_job", 64'(busy), 0);
        check("err", 64'(err), 64'(e.e_err));
        check("wt_ld_tx", 64'(wt_tx), 64'(e.e_wt));
        check("pe_starts", 64'(st_cnt), 64'(e.e_st));
        check("rd_en_cycles", 64'(rd_cnt), 64'(e.e_rd));
        check("wr_en_cycles", 64'(wr_cnt), 64'(e.e_wr));
        stall_mode = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        vec_t tv, av;
        int   n;
        tab[0] = '{2, 15, 15, 1'b0, 1'b0, 0, 1, 2, 30, 30};
        tab[1] = '{2, 15, 15, 1'b1, 1'b0, 0, 2, 2, 30, 30};
        tab[2] = '{1,  4,  4, 1'b0, 1'b1, 0, 1, 1,  4,  4};
        tab[3] = '{3,  4,  7, 1'b0, 1'b0, 0, 1, 3, 12, 21};
        tab[4] = '{3,  2,  3, 1'b1, 1'b1, 0, 3, 3,  6,  9};
        tab[5] = '{1,  0,  5, 1'b0, 1'b0, 1, 0, 0,  0,  0};
        tab[6] = '{0,  5,  5, 1'b0, 1'b0, 1, 0, 0,  0,  0};
        tab[7] = '{2,  3,  0, 1'b1, 1'b0, 1, 0, 0,  0,  0};

        rst_n = 0; start = 0; abort = 0;
        cfg_num_tiles = '0; cfg_if_rows = '0; cfg_of_rows = '0;
        cfg_wt_reload = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", 64'(outv), 0);
        @(posedge clk); #1;
        rst_n = 1;
        @(negedge clk);
        check("idle_outputs", 64'(outv), 0);

        for (int i = 0; i < 8; i++) run_job(tab[i], 1'b1);

        tv = '{1, 2, 2, 1'b0, 1'b0, 2, 1, 1, 2, 0};
        run_job(tv, 1'b0);
        check("timeout_latency", 64'(done_cyc - pe_start_cyc), 22);

        tv = '{1, 0, 5, 1'b0, 1'b0, 1, 0, 0, 0, 0};
        run_job(tv, 1'b1);
        check("cfg_err_latency", 64'(done_cyc - start_cyc), 1);
        check("cfg_err_no_req", 64'(req_seen), 0);

        av = '{1, 3, 8, 1'b0, 1'b0, 0, 0, 0, 0, 0};
        kick(av, 1'b1);
        n = 0;
        while (n < BUDGET && !(state_o == 3'd5 && wr_cnt >= 2)) begin
            @(posedge clk); #1;
            n++;
        end
        check("abort_reach_unload", 64'(n < BUDGET), 1);
        abort = 1'b1;
        @(negedge clk);
        check("abort_strobes", 64'(strb), 0);
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        check("abort_idle_outputs", 64'(outv), 0);
        repeat (6) @(posedge clk);
        check("abort_no_done", 64'(done_cnt), 0);

        run_job(tab[0], 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
